// File: rtl/ibex_rf_pkg.sv
// ibex_rf_pkg
//   Shared definitions for the FPGA register-file write sequencer:
//   - RfAddrW        : register address width
//   - rf_seq_state_e : sequencer state (init sweep / normal run)
//   - num_regs()     : architectural register count for RV32E / RV32I
package ibex_rf_pkg;

   localparam int unsigned RfAddrW = 5;

   typedef enum logic {
      RF_SEQ_INIT = 1'b0,
      RF_SEQ_RUN  = 1'b1
   } rf_seq_state_e;

   function automatic int unsigned num_regs(input bit rv32e);
      return rv32e ? 32'd16 : 32'd32;
   endfunction

endpackage

// File: rtl/ibex_rf_wr_arb.sv
// ibex_rf_wr_arb
//   Two-requester grant for the register-file write port while the
//   sequencer is running. A (writeback) has fixed priority; B (debug /
//   external) is forced through after being blocked MaxWait cycles.
// Ports:
//   clk_i, rst_i             clock, async active-high reset
//   en_i                     sequencer is in RUN; no grants otherwise
//   clr_i                    clear the wait counter (init sweep restarting)
//   a_valid_i / a_ready_o    requester A handshake
//   b_valid_i / b_ready_o    requester B handshake
module ibex_rf_wr_arb #(
   parameter int unsigned MaxWait = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   input  logic a_valid_i,
   output logic a_ready_o,
   input  logic b_valid_i,
   output logic b_ready_o
);

   // MaxWait=0 would give a zero-width counter; keep one bit that never moves.
   localparam int unsigned   CntW   = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(MaxWait);
   localparam bit            ForceEn = (MaxWait > 0);

   logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
   logic            force_b;

   always_comb begin
      force_b   = ForceEn && (wait_cnt_q == CntMax) && b_valid_i;
      a_ready_o = en_i & a_valid_i & ~force_b;
      b_ready_o = en_i & b_valid_i & (~a_valid_i | force_b);

      wait_cnt_d = '0;
      if (en_i && !clr_i && b_valid_i && !b_ready_o) begin
         wait_cnt_d = (wait_cnt_q == CntMax) ? wait_cnt_q : wait_cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

endmodule

// File: rtl/ibex_rf_wr_sequencer.sv
// ibex_rf_wr_sequencer
//   Owns the single write port of the FPGA register file. After reset (or
//   on init_req_i) it sweeps x1..x(NumRegs-1) with InitVal, then arbitrates
//   the port between writeback (A) and the debug/external path (B).
//   Optional feature macro: IBEX_RF_WR_SEQ_ERR_EN -- B writes to x0 (or to
//   x16+ when RV32E) are acknowledged but dropped and flagged on err_o.
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   init_req_i                       restart the sweep (honoured in RUN only)
//   a_valid_i/a_ready_o/a_addr_i/a_data_i   requester A
//   b_valid_i/b_ready_o/b_addr_i/b_data_i   requester B
//   rf_waddr_o/rf_wdata_o/rf_we_o    registered register-file write port
//   init_done_o                      high while in RUN
//   err_o                            one-cycle pulse on a dropped illegal B write
module ibex_rf_wr_sequencer
   import ibex_rf_pkg::*;
#(
   parameter bit                   RV32E     = 1'b0,
   parameter int unsigned          DataWidth = 32,
   parameter logic [DataWidth-1:0] InitVal   = '0,
   parameter int unsigned          MaxWait   = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 init_req_i,
   input  logic                 a_valid_i,
   output logic                 a_ready_o,
   input  logic [RfAddrW-1:0]   a_addr_i,
   input  logic [DataWidth-1:0] a_data_i,
   input  logic                 b_valid_i,
   output logic                 b_ready_o,
   input  logic [RfAddrW-1:0]   b_addr_i,
   input  logic [DataWidth-1:0] b_data_i,
   output logic [RfAddrW-1:0]   rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   output logic                 rf_we_o,
   output logic                 init_done_o,
   output logic                 err_o
);

   localparam logic [RfAddrW-1:0] LastAddr  = RfAddrW'(num_regs(RV32E) - 1);
   localparam logic [RfAddrW-1:0] FirstAddr = RfAddrW'(1);

   rf_seq_state_e        state_q, state_d;
   logic [RfAddrW-1:0]   sweep_addr_q, sweep_addr_d;
   logic [RfAddrW-1:0]   rf_waddr_q, rf_waddr_d;
   logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
   logic                 rf_we_q, rf_we_d;
   logic                 err_q, err_d;
   logic                 run;
   logic                 b_illegal;

   assign run = (state_q == RF_SEQ_RUN);

`ifdef IBEX_RF_WR_SEQ_ERR_EN
   assign b_illegal = (b_addr_i == '0) || (RV32E && b_addr_i[RfAddrW-1]);
`else
   assign b_illegal = 1'b0;
`endif

   ibex_rf_wr_arb #(
      .MaxWait (MaxWait)
   ) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (run),
      .clr_i     (init_req_i),
      .a_valid_i (a_valid_i),
      .a_ready_o (a_ready_o),
      .b_valid_i (b_valid_i),
      .b_ready_o (b_ready_o)
   );

   always_comb begin
      state_d      = state_q;
      sweep_addr_d = sweep_addr_q;
      rf_waddr_d   = rf_waddr_q;   // addr/data hold when no write is issued
      rf_wdata_d   = rf_wdata_q;
      rf_we_d      = 1'b0;
      err_d        = 1'b0;

      unique case (state_q)
         RF_SEQ_INIT: begin
            rf_waddr_d = sweep_addr_q;
            rf_wdata_d = InitVal;
            rf_we_d    = 1'b1;
            if (sweep_addr_q == LastAddr) begin
               sweep_addr_d = FirstAddr;
               state_d      = RF_SEQ_RUN;
            end else begin
               sweep_addr_d = sweep_addr_q + RfAddrW'(1);
            end
         end
         RF_SEQ_RUN: begin
            // The arbiter grants at most one requester per cycle.
            if (a_ready_o) begin
               rf_waddr_d = a_addr_i;
               rf_wdata_d = a_data_i;
               rf_we_d    = 1'b1;
            end else if (b_ready_o) begin
               if (b_illegal) begin
                  err_d = 1'b1;
               end else begin
                  rf_waddr_d = b_addr_i;
                  rf_wdata_d = b_data_i;
                  rf_we_d    = 1'b1;
               end
            end
            // Same-cycle handshake above still lands; sweep restarts next cycle.
            if (init_req_i) begin
               state_d      = RF_SEQ_INIT;
               sweep_addr_d = FirstAddr;
            end
         end
         default: begin
            state_d      = RF_SEQ_INIT;
            sweep_addr_d = FirstAddr;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= RF_SEQ_INIT;
         sweep_addr_q <= FirstAddr;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
         rf_we_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sweep_addr_q <= sweep_addr_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
         rf_we_q      <= rf_we_d;
         err_q        <= err_d;
      end
   end

   assign rf_waddr_o  = rf_waddr_q;
   assign rf_wdata_o  = rf_wdata_q;
   assign rf_we_o     = rf_we_q;
   assign err_o       = err_q;
   assign init_done_o = run;

endmodule

// File: tb/tb_ibex_rf_wr_sequencer.sv
// tb_ibex_rf_wr_sequencer
//   Directed bench. dut0: RV32I, InitVal DEADBEEF, MaxWait 4.
//   dut1: RV32E, InitVal 0, MaxWait 0 (strict A priority). Both share inputs.
module tb_ibex_rf_wr_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init_req = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic [4:0]  a_addr = '0, b_addr = '0;
   logic [31:0] a_data = '0, b_data = '0;

   logic        a_ready0, b_ready0, we0, done0, err0;
   logic [4:0]  waddr0;
   logic [31:0] wdata0;
   logic        a_ready1, b_ready1, we1, done1, err1;
   logic [4:0]  waddr1;
   logic [31:0] wdata1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ibex_rf_wr_sequencer #(
      .RV32E(1'b0), .DataWidth(32), .InitVal(32'hDEAD_BEEF), .MaxWait(4)
   ) dut0 (
      .clk_i(clk), .rst_i(rst), .init_req_i(init_req),
      .a_valid_i(a_valid), .a_ready_o(a_ready0), .a_addr_i(a_addr), .a_data_i(a_data),
      .b_valid_i(b_valid), .b_ready_o(b_ready0), .b_addr_i(b_addr), .b_data_i(b_data),
      .rf_waddr_o(waddr0), .rf_wdata_o(wdata0), .rf_we_o(we0),
      .init_done_o(done0), .err_o(err0)
   );

   ibex_rf_wr_sequencer #(
      .RV32E(1'b1), .DataWidth(32), .InitVal(32'h0), .MaxWait(0)
   ) dut1 (
      .clk_i(clk), .rst_i(rst), .init_req_i(init_req),
      .a_valid_i(a_valid), .a_ready_o(a_ready1), .a_addr_i(a_addr), .a_data_i(a_data),
      .b_valid_i(b_valid), .b_ready_o(b_ready1), .b_addr_i(b_addr), .b_data_i(b_data),
      .rf_waddr_o(waddr1), .rf_wdata_o(wdata1), .rf_we_o(we1),
      .init_done_o(done1), .err_o(err1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full 31-register sweep on dut0 starting from INIT with sweep addr 1.
   // init_req is held for the first cycles to show it is ignored in INIT.
   task automatic sweep0();
      for (int k = 1; k <= 31; k++) begin
         chk("sweep_a_ready", a_ready0, 0);
         chk("sweep_b_ready", b_ready0, 0);
         chk("sweep_done_low", done0, 0);
         tick();
         if (k == 3) init_req = 1'b0;
         chk("sweep_we", we0, 1);
         chk("sweep_addr", waddr0, k);
         chk("sweep_data", wdata0, 32'hDEAD_BEEF);
      end
      chk("sweep_done_high", done0, 1);
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_we", we0, 0);
      chk("rst_addr", waddr0, 0);
      chk("rst_data", wdata0, 0);
      chk("rst_done", done0, 0);
      chk("rst_err", err0, 0);
      chk("rst_done1", done1, 0);
      @(negedge clk);
      rst = 1'b0;
      a_valid = 1'b1;
      b_valid = 1'b1;
      #1;
      sweep0();
      tick();
      chk("post_sweep_we", we0, 0);

      // Both requesters valid: dut0 gives AAAAB, dut1 never grants B
      a_addr = 5'd7;  a_data = 32'hAAAA_0007;
      b_addr = 5'd9;  b_data = 32'hBBBB_0009;
      a_valid = 1'b1; b_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         #1;
         chk("arb_a_ready", a_ready0, (c % 5) != 4);
         chk("arb_b_ready", b_ready0, (c % 5) == 4);
         chk("strict_b_ready", b_ready1, 0);
         chk("strict_a_ready", a_ready1, 1);
         tick();
         chk("arb_we", we0, 1);
         chk("arb_addr", waddr0, ((c % 5) == 4) ? 32'd9 : 32'd7);
         chk("strict_addr", waddr1, 7);
      end
      a_valid = 1'b0;
      #1;
      chk("strict_b_after_a", b_ready1, 1);
      tick();
      chk("strict_b_we", we1, 1);
      chk("strict_b_addr", waddr1, 9);
      chk("strict_b_data", wdata1, 32'hBBBB_0009);
      b_valid = 1'b0;
      tick();
      chk("idle_we", we1, 0);

      // init_req with a same-cycle A handshake
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0000_1234;
      init_req = 1'b1;
      #1;
      chk("ireq_a_ready", a_ready0, 1);
      tick();
      chk("ireq_we", we0, 1);
      chk("ireq_addr", waddr0, 5);
      chk("ireq_data", wdata0, 32'h1234);
      chk("ireq_done", done0, 0);
      b_valid = 1'b1;
      sweep0();
      tick();
      chk("ireq_post_we", we0, 0);

      // Reset in the middle of a sweep
      init_req = 1'b1;
      tick();
      init_req = 1'b0;
      chk("mid_init", done0, 0);
      repeat (17) tick();
      chk("mid_we", we0, 1);
      chk("mid_addr", waddr0, 17);
      rst = 1'b1;
      #1;
      chk("mid_rst_we", we0, 0);
      chk("mid_rst_addr", waddr0, 0);
      chk("mid_rst_data", wdata0, 0);
      @(negedge clk);
      rst = 1'b0;
      a_valid = 1'b1;
      b_valid = 1'b1;
      #1;
      sweep0();
      tick();
      chk("mid_post_we", we0, 0);

      // B address checking
      b_valid = 1'b1; b_addr = 5'd20; b_data = 32'h55;
      #1;
      chk("err_b_ready1", b_ready1, 1);
      chk("err_b_ready0", b_ready0, 1);
      tick();
`ifdef IBEX_RF_WR_SEQ_ERR_EN
      chk("err20_we1", we1, 0);
      chk("err20_err1", err1, 1);
`else
      chk("pass20_we1", we1, 1);
      chk("pass20_addr1", waddr1, 20);
      chk("pass20_err1", err1, 0);
`endif
      chk("legal20_we0", we0, 1);
      chk("legal20_addr0", waddr0, 20);
      chk("legal20_err0", err0, 0);
      b_addr = 5'd3; b_data = 32'h66;
      tick();
      chk("b3_we1", we1, 1);
      chk("b3_addr1", waddr1, 3);
      chk("b3_data1", wdata1, 32'h66);
      chk("b3_err1", err1, 0);
      b_addr = 5'd0;
      tick();
`ifdef IBEX_RF_WR_SEQ_ERR_EN
      chk("x0_we0", we0, 0);
      chk("x0_err0", err0, 1);
`else
      chk("x0_we0", we0, 1);
      chk("x0_addr0", waddr0, 0);
      chk("x0_err0", err0, 0);
`endif
      b_valid = 1'b0;
      tick();
      chk("err_clear0", err0, 0);
      chk("err_clear1", err1, 0);
      chk("err_clear_we", we0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ibex_rf_wr_sequencer.md
Name: ibex_rf_wr_sequencer

Overview:
- Owns the single write port of the FPGA register file.
- After reset, or on request, sweeps every architectural register (x1 upward) to a fixed init value so the RAM-inferred array never holds X/garbage.
- In normal operation, arbitrates the write port between two requesters: A is writeback with fixed priority; B is the debug/external write path, protected by an anti-starvation counter.
- Sits between the ID/WB stage and the register file write port; drives waddr/wdata/we directly.

Parameters:
- RV32E, 0, 1 = 16 registers (sweep x1..x15); 0 = 32 registers (sweep x1..x31).
- DataWidth, 32, register word width.
- InitVal, '0, value written to every register during the sweep.
- MaxWait, 4, cycles B may be blocked by A before B is forced through. 0 = strict A priority, no forcing. Counter width is $clog2(MaxWait+1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- init_req_i  in  1  restart the init sweep; sampled in RUN only
- a_valid_i  in  1  requester A write valid
- a_ready_o  out  1  requester A accepted
- a_addr_i  in  5  requester A destination
- a_data_i  in  DataWidth  requester A data
- b_valid_i  in  1  requester B write valid
- b_ready_o  out  1  requester B accepted
- b_addr_i  in  5  requester B destination
- b_data_i  in  DataWidth  requester B data
- rf_waddr_o  out  5  to register file waddr_a_i
- rf_wdata_o  out  DataWidth  to register file wdata_a_i
- rf_we_o  out  1  to register file we_a_i
- init_done_o  out  1  high while in RUN
- err_o  out  1  illegal B write detected (optional feature only)

Behaviour:
- Reset values: all outputs 0; state INIT; sweep address 1; wait counter 0.
- Port outputs are registered. A request accepted in cycle N appears on rf_* in cycle N+1 with rf_we_o=1 for exactly one cycle. Otherwise rf_we_o=0; addr and data hold their last value.
- State INIT:
  - a_ready_o=b_ready_o=0.
  - Each cycle, issue a write of InitVal to the sweep address, then increment it.
  - After issuing NumRegs-1 (31 or 15) go to RUN. init_done_o rises the cycle after the last write is issued.
  - Sweep is exactly NumRegs-1 cycles. Address wraps from NumRegs-1 back to 1 for the next sweep.
  - x0 is never written.
- State RUN:
  - Default grant: a_ready_o=a_valid_i. b_ready_o=b_valid_i & ~a_valid_i.
  - Force condition: MaxWait>0 and wait counter == MaxWait and b_valid_i. When forced, b_ready_o=1 and a_ready_o=0; A stalls for one cycle.
  - Wait counter increments while b_valid_i & ~b_ready_o, saturating at MaxWait. It clears on a B handshake or when b_valid_i=0.
  - Ready is combinational from valid and state. Requesters must hold valid, addr and data stable until ready.
- init_req_i in RUN:
  - Any handshake in the same cycle completes normally.
  - Next cycle the state is INIT: sweep address 1, counter cleared, init_done_o=0.
  - init_req_i during INIT is ignored.
- Reset mid-sweep or mid-write: async return to reset values. A write in flight is dropped (rf_we_o forced to 0).
- Address handling: addresses pass through unmodified unless the optional feature is on. With RV32E=1 the upper address bit is not checked.

Optional Feature:
- Macro: IBEX_RF_WR_SEQ_ERR_EN.
- With the macro defined:
  - A B request to x0, or to any address >= 16 when RV32E=1, is still handshaken (b_ready_o as normal).
  - No write is issued for it (rf_we_o stays 0).
  - err_o pulses high for one cycle, registered, in the cycle the write would have appeared.
- Without the macro: err_o tied 0, and B addresses pass unchecked.

Decomposition:
- Shared package ibex_rf_pkg holds:
  - typedef rf_seq_state_e {RF_SEQ_INIT, RF_SEQ_RUN}
  - function num_regs(RV32E)
  - localparam RfAddrW=5
- One sub-module is natural: ibex_rf_wr_arb. It holds the two-requester priority grant and the starvation counter, with a purely RUN-state interface. The top-level module keeps the FSM, the sweep counter and the output registers.

Test Plan:
- Reset release, RV32E=0, InitVal=32'hDEAD_BEEF -> 31 consecutive rf_we_o pulses, addr 1..31, data DEADBEEF; init_done_o high on cycle 32; readies 0 throughout.
- RUN, A and B both valid every cycle, MaxWait=4 -> grants AAAA B AAAA B...; B accepted every 5th cycle; rf_waddr_o matches the granted requester one cycle later.
- MaxWait=0, A continuously valid for 20 cycles, B valid -> B never granted; B granted the cycle after A drops.
- init_req_i asserted with an A handshake in the same cycle (addr 5, data 0x1234) -> that write appears on rf_*; next cycle INIT restarts at addr 1; readies 0 for 31 cycles.
- rst_i asserted at sweep addr 17 -> rf_we_o=0 immediately; after release the sweep restarts at addr 1 and runs a full 31 writes.
- With IBEX_RF_WR_SEQ_ERR_EN and RV32E=1, B write to addr 20 -> b_ready_o=1, no rf_we_o, err_o one-cycle pulse. B write to addr 3 -> normal write, err_o=0.
